// File: rtl/core_pkg.sv
//==============================================================================
// Module      : core_pkg
// Description : Shared definitions for the 5-stage RISC-V core: result-select
//               and ALU encodings, default widths, E-stage control bundle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package core_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int ALUCTRL_W_DEF = 3;

  // ResultSrc encodings; RESULT_LOAD marks an instruction whose result comes
  // from data memory and is therefore not available for forwarding from E.
  localparam logic [1:0] RESULT_ALU  = 2'b00;
  localparam logic [1:0] RESULT_LOAD = 2'b01;
  localparam logic [1:0] RESULT_PC4  = 2'b10;

  // ALUControl encodings
  localparam logic [ALUCTRL_W_DEF-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUCTRL_W_DEF-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUCTRL_W_DEF-1:0] ALU_AND = 3'b010;
  localparam logic [ALUCTRL_W_DEF-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUCTRL_W_DEF-1:0] ALU_SLT = 3'b101;

  // Control bundle carried from D into E. An all-zero value is a bubble.
  typedef struct packed {
    logic                     reg_write;
    logic [1:0]               result_src;
    logic                     mem_write;
    logic                     jump;
    logic                     branch;
    logic [ALUCTRL_W_DEF-1:0] alu_control;
    logic                     alu_src;
    logic                     valid;
  } e_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
//==============================================================================
// Module      : load_use_detect
// Description : Combinational load-use hazard detector. Flags a D-stage
//               instruction that reads the destination of a load sitting in E.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module load_use_detect
  import core_pkg::*;
(
  input  logic       valid_e,
  input  logic       reg_write_e,
  input  logic [1:0] result_src_e,
  input  logic [4:0] rd_e,
  input  logic       valid_d,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  output logic       lw_stall
);

  logic load_in_e;
  logic src_match;

  // A bubble in E (valid_e=0) or a write to x0 can never create a hazard.
  always_comb begin
    load_in_e = valid_e && reg_write_e && (result_src_e == RESULT_LOAD) && (rd_e != 5'd0);
    src_match = (rs1_d == rd_e) || (rs2_d == rd_e);
    lw_stall  = load_in_e && valid_d && src_match;
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
//==============================================================================
// Module      : id_ex_stage
// Description : D-to-E pipeline register with load-use hazard detection,
//               F/D stall and D/E flush generation, and saturating bubble /
//               load-use statistics counters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int ALUCTRL_W = ALUCTRL_W_DEF,
  parameter int CNT_W     = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ValidD,
  input  logic [XLEN-1:0]      RD1D,
  input  logic [XLEN-1:0]      RD2D,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           RdD,
  input  logic [XLEN-1:0]      ImmExtD,
  input  logic [XLEN-1:0]      PCD,
  input  logic [XLEN-1:0]      PCPlus4D,
  input  logic                 RegWriteD,
  input  logic                 MemWriteD,
  input  logic                 JumpD,
  input  logic                 BranchD,
  input  logic                 ALUSrcD,
  input  logic [1:0]           ResultSrcD,
  input  logic [ALUCTRL_W-1:0] ALUControlD,
  input  logic                 PCSrcE,
  output logic [XLEN-1:0]      RD1E,
  output logic [XLEN-1:0]      RD2E,
  output logic [XLEN-1:0]      ImmExtE,
  output logic [XLEN-1:0]      PCE,
  output logic [XLEN-1:0]      PCPlus4E,
  output logic [4:0]           Rs1E,
  output logic [4:0]           Rs2E,
  output logic [4:0]           RdE,
  output logic                 RegWriteE,
  output logic                 MemWriteE,
  output logic                 JumpE,
  output logic                 BranchE,
  output logic                 ALUSrcE,
  output logic                 ValidE,
  output logic [1:0]           ResultSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic [CNT_W-1:0]     BubbleCount,
  output logic [CNT_W-1:0]     LoadUseCount
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  e_ctrl_t             ctrl_next, ctrl_q;
  logic [XLEN-1:0]     rd1_next, rd2_next, imm_next, pc_next, pc4_next;
  logic [XLEN-1:0]     rd1_q, rd2_q, imm_q, pc_q, pc4_q;
  logic [4:0]          rs1_next, rs2_next, rd_next;
  logic [4:0]          rs1_q, rs2_q, rd_q;
  logic                lw_stall;
  logic                flush_e;
  logic [CNT_W-1:0]    bubble_cnt, load_use_cnt;

  load_use_detect u_load_use_detect (
    .valid_e      (ctrl_q.valid),
    .reg_write_e  (ctrl_q.reg_write),
    .result_src_e (ctrl_q.result_src),
    .rd_e         (rd_q),
    .valid_d      (ValidD),
    .rs1_d        (Rs1D),
    .rs2_d        (Rs2D),
    .lw_stall     (lw_stall)
  );

  // Hazard controls: a stall holds F/D and injects a bubble; a taken
  // branch/jump kills both the D and E slots.
  always_comb begin
    flush_e = lw_stall || PCSrcE;
    StallF  = lw_stall;
    StallD  = lw_stall;
    FlushD  = PCSrcE;
    FlushE  = flush_e;
  end

  // Next E contents: D values, or an all-zero bubble when E is flushed.
  always_comb begin
    ctrl_next.reg_write   = RegWriteD;
    ctrl_next.result_src  = ResultSrcD;
    ctrl_next.mem_write   = MemWriteD;
    ctrl_next.jump        = JumpD;
    ctrl_next.branch      = BranchD;
    ctrl_next.alu_control = ALUControlD;
    ctrl_next.alu_src     = ALUSrcD;
    ctrl_next.valid       = ValidD;
    rd1_next = RD1D;
    rd2_next = RD2D;
    imm_next = ImmExtD;
    pc_next  = PCD;
    pc4_next = PCPlus4D;
    rs1_next = Rs1D;
    rs2_next = Rs2D;
    rd_next  = RdD;
    if (flush_e) begin
      ctrl_next = '0;
      rd1_next  = '0;
      rd2_next  = '0;
      imm_next  = '0;
      pc_next   = '0;
      pc4_next  = '0;
      rs1_next  = '0;
      rs2_next  = '0;
      rd_next   = '0;
    end
  end

  // E-stage register: loads every cycle, never holds.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ctrl_q <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      pc_q   <= '0;
      pc4_q  <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
    end else begin
      ctrl_q <= ctrl_next;
      rd1_q  <= rd1_next;
      rd2_q  <= rd2_next;
      imm_q  <= imm_next;
      pc_q   <= pc_next;
      pc4_q  <= pc4_next;
      rs1_q  <= rs1_next;
      rs2_q  <= rs2_next;
      rd_q   <= rd_next;
    end
  end

  // Saturating statistics: bubbles injected and load-use stalls taken.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bubble_cnt   <= '0;
      load_use_cnt <= '0;
    end else begin
      if (flush_e && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + CNT_ONE;
      end
      if (lw_stall && (load_use_cnt != '1)) begin
        load_use_cnt <= load_use_cnt + CNT_ONE;
      end
    end
  end

  // Drive registered outputs.
  always_comb begin
    RD1E         = rd1_q;
    RD2E         = rd2_q;
    ImmExtE      = imm_q;
    PCE          = pc_q;
    PCPlus4E     = pc4_q;
    Rs1E         = rs1_q;
    Rs2E         = rs2_q;
    RdE          = rd_q;
    RegWriteE    = ctrl_q.reg_write;
    ResultSrcE   = ctrl_q.result_src;
    MemWriteE    = ctrl_q.mem_write;
    JumpE        = ctrl_q.jump;
    BranchE      = ctrl_q.branch;
    ALUControlE  = ctrl_q.alu_control;
    ALUSrcE      = ctrl_q.alu_src;
    ValidE       = ctrl_q.valid;
    BubbleCount  = bubble_cnt;
    LoadUseCount = load_use_cnt;
  end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
//==============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage with a scoreboard queue
//               fed by a reference model and drained by a monitor.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_id_ex_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ValidD;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;
  logic        PCSrcE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic        StallF, StallD, FlushD, FlushE;
  logic [15:0] BubbleCount, LoadUseCount;

  id_ex_stage dut (
    .CLK(CLK), .RST(RST), .ValidD(ValidD),
    .RD1D(RD1D), .RD2D(RD2D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD), .PCSrcE(PCSrcE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ValidE(ValidE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .BubbleCount(BubbleCount), .LoadUseCount(LoadUseCount)
  );

  always #5 CLK = ~CLK;

  // Architectural view of the E stage plus the statistics counters.
  typedef struct packed {
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic        reg_write, mem_write, jump, branch, alu_src, valid;
    logic [1:0]  result_src;
    logic [2:0]  alu_control;
    logic [15:0] bub, lu;
  } obs_t;

  obs_t q[$];
  obs_t m_e;
  int   bub_m, lu_m;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t dut_obs();
    obs_t o;
    o.rd1 = RD1E; o.rd2 = RD2E; o.imm = ImmExtE; o.pc = PCE; o.pc4 = PCPlus4E;
    o.rs1 = Rs1E; o.rs2 = Rs2E; o.rd = RdE;
    o.reg_write = RegWriteE; o.mem_write = MemWriteE; o.jump = JumpE;
    o.branch = BranchE; o.alu_src = ALUSrcE; o.valid = ValidE;
    o.result_src = ResultSrcE; o.alu_control = ALUControlE;
    o.bub = BubbleCount; o.lu = LoadUseCount;
    return o;
  endfunction

  function automatic logic [255:0] data_of(input obs_t o);
    return 256'({o.rd1, o.rd2, o.imm, o.pc, o.pc4, o.rs1, o.rs2, o.rd});
  endfunction

  function automatic logic [255:0] ctrl_of(input obs_t o);
    return 256'({o.reg_write, o.mem_write, o.jump, o.branch, o.alu_src, o.valid,
                  o.result_src, o.alu_control});
  endfunction

  function automatic logic [255:0] all_out();
    return 256'({dut_obs(), StallF, StallD, FlushD, FlushE});
  endfunction

  // Monitor: every edge out of reset produces a new E value to compare.
  always @(posedge CLK) begin : monitor
    obs_t exp_o, act_o;
    #1;
    if (!RST && (q.size() > 0)) begin
      exp_o = q.pop_front();
      act_o = dut_obs();
      chk("e_data", data_of(act_o), data_of(exp_o));
      chk("e_ctrl", ctrl_of(act_o), ctrl_of(exp_o));
      chk("counters", 256'({act_o.bub, act_o.lu}), 256'({exp_o.bub, exp_o.lu}));
    end
  end

  task automatic reset_model();
    m_e   = '0;
    bub_m = 0;
    lu_m  = 0;
    q.delete();
  endtask

  task automatic clear_d();
    ValidD = 1'b0; RD1D = '0; RD2D = '0; ImmExtD = '0; PCD = '0; PCPlus4D = '0;
    Rs1D = '0; Rs2D = '0; RdD = '0; RegWriteD = 1'b0; MemWriteD = 1'b0;
    JumpD = 1'b0; BranchD = 1'b0; ALUSrcD = 1'b0; ResultSrcD = '0;
    ALUControlD = '0; PCSrcE = 1'b0;
  endtask

  // Small register index range so hazards occur often.
  task automatic rand_d();
    ValidD      = ($urandom_range(0, 7) != 0);
    RD1D        = $urandom;
    RD2D        = $urandom;
    ImmExtD     = $urandom;
    PCD         = $urandom;
    PCPlus4D    = PCD + 32'd4;
    Rs1D        = 5'($urandom_range(0, 3));
    Rs2D        = 5'($urandom_range(0, 3));
    RdD         = 5'($urandom_range(0, 3));
    RegWriteD   = 1'($urandom_range(0, 1));
    MemWriteD   = 1'($urandom_range(0, 1));
    JumpD       = 1'($urandom_range(0, 1));
    BranchD     = 1'($urandom_range(0, 1));
    ALUSrcD     = 1'($urandom_range(0, 1));
    ResultSrcD  = 2'($urandom_range(0, 3));
    ALUControlD = 3'($urandom_range(0, 7));
    PCSrcE      = ($urandom_range(0, 7) == 0);
  endtask

  task automatic load_d(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic rw, input logic [1:0] rsrc, input logic pcs);
    rand_d();
    ValidD = 1'b1; Rs1D = rs1; Rs2D = rs2; RdD = rd;
    RegWriteD = rw; ResultSrcD = rsrc; PCSrcE = pcs;
  endtask

  // Reference model: hazard rule evaluated on the modelled E contents, then
  // the next E contents and counters queued for the monitor.
  task automatic do_cycle();
    logic lw, fl;
    obs_t nx;
    lw = m_e.valid && m_e.reg_write && (m_e.result_src == 2'b01) && (m_e.rd != 5'd0) &&
         ValidD && ((Rs1D == m_e.rd) || (Rs2D == m_e.rd));
    fl = lw || PCSrcE;
    @(negedge CLK);
    chk("hazard", 256'({StallF, StallD, FlushD, FlushE}), 256'({lw, lw, PCSrcE, fl}));
    nx = '0;
    if (!fl) begin
      nx.rd1 = RD1D; nx.rd2 = RD2D; nx.imm = ImmExtD; nx.pc = PCD; nx.pc4 = PCPlus4D;
      nx.rs1 = Rs1D; nx.rs2 = Rs2D; nx.rd = RdD;
      nx.reg_write = RegWriteD; nx.mem_write = MemWriteD; nx.jump = JumpD;
      nx.branch = BranchD; nx.alu_src = ALUSrcD; nx.valid = ValidD;
      nx.result_src = ResultSrcD; nx.alu_control = ALUControlD;
    end
    if (fl && (bub_m < 65535)) bub_m++;
    if (lw && (lu_m < 65535)) lu_m++;
    nx.bub = 16'(bub_m);
    nx.lu  = 16'(lu_m);
    q.push_back(nx);
    m_e = nx;
    @(posedge CLK);
    #2;
  endtask

  initial begin
    RST = 1'b1;
    clear_d();
    reset_model();
    @(posedge CLK);
    #2;
    RST = 1'b0;
    chk("reset_init", all_out(), 256'd0);

    // Passthrough
    load_d(5'd1, 5'd2, 5'd5, 1'b1, 2'b00, 1'b0);
    RD1D = 32'h12345678; ImmExtD = 32'hFFFFFFF0; ALUControlD = 3'b010;
    #1;
    chk("pass_nohaz", 256'({StallF, StallD, FlushD, FlushE}), 256'd0);
    do_cycle();
    chk("pass_rd1", 256'(RD1E), 256'(32'h12345678));
    chk("pass_imm", 256'(ImmExtE), 256'(32'hFFFFFFF0));
    chk("pass_rd", 256'(RdE), 256'(5'd5));
    chk("pass_alu", 256'(ALUControlE), 256'(3'b010));
    chk("pass_valid", 256'(ValidE), 256'(1'b1));

    // Load-use: load to x7 in E, consumer reads x7 via Rs2
    load_d(5'd1, 5'd2, 5'd7, 1'b1, 2'b01, 1'b0);
    do_cycle();
    load_d(5'd3, 5'd7, 5'd9, 1'b1, 2'b00, 1'b0);
    #1;
    chk("lu_stall", 256'({StallF, StallD, FlushE}), 256'(3'b111));
    do_cycle();
    chk("lu_bubble", 256'(ValidE), 256'(1'b0));
    chk("lu_count", 256'(LoadUseCount), 256'(16'd1));
    chk("lu_bubcount", 256'(BubbleCount), 256'(16'd1));
    load_d(5'd3, 5'd7, 5'd9, 1'b1, 2'b00, 1'b0);
    #1;
    chk("lu_once", 256'(StallF), 256'(1'b0));
    do_cycle();

    // No false stall: x0 destination, and non-load writer
    load_d(5'd1, 5'd2, 5'd0, 1'b1, 2'b01, 1'b0);
    do_cycle();
    load_d(5'd0, 5'd0, 5'd4, 1'b1, 2'b00, 1'b0);
    #1;
    chk("rd0_nostall", 256'(StallF), 256'(1'b0));
    do_cycle();
    load_d(5'd1, 5'd2, 5'd7, 1'b1, 2'b00, 1'b0);
    do_cycle();
    load_d(5'd7, 5'd1, 5'd3, 1'b1, 2'b00, 1'b0);
    #1;
    chk("nonload_nostall", 256'(StallF), 256'(1'b0));
    do_cycle();

    // Branch flush
    load_d(5'd1, 5'd2, 5'd3, 1'b1, 2'b00, 1'b1);
    #1;
    chk("br_flush", 256'({FlushD, FlushE, StallF}), 256'(3'b110));
    do_cycle();
    chk("br_bubble", 256'(ValidE), 256'(1'b0));
    chk("br_counts", 256'({BubbleCount, LoadUseCount}), 256'({16'd2, 16'd1}));

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rand_d();
      do_cycle();
    end

    // Asynchronous reset while a load-use stall is active
    clear_d();
    do_cycle();
    load_d(5'd1, 5'd2, 5'd6, 1'b1, 2'b01, 1'b0);
    do_cycle();
    load_d(5'd6, 5'd2, 5'd3, 1'b1, 2'b00, 1'b0);
    #1;
    chk("pre_rst_stall", 256'(StallF), 256'(1'b1));
    #1;
    RST = 1'b1;
    #1;
    chk("rst_async", all_out(), 256'd0);
    @(posedge CLK);
    #2;
    RST = 1'b0;
    reset_model();

    // Drive BubbleCount into saturation with back-to-back taken branches
    for (int i = 0; i < 65540; i++) begin
      rand_d();
      PCSrcE = 1'b1;
      do_cycle();
    end
    chk("bub_sat", 256'(BubbleCount), 256'(16'hFFFF));

    // Simultaneous load-use and taken branch at saturation
    load_d(5'd1, 5'd2, 5'd7, 1'b1, 2'b01, 1'b0);
    do_cycle();
    load_d(5'd7, 5'd7, 5'd2, 1'b1, 2'b00, 1'b1);
    #1;
    chk("both_haz", 256'({StallF, StallD, FlushD, FlushE}), 256'(4'b1111));
    do_cycle();
    chk("both_bubble", 256'(ValidE), 256'(1'b0));
    chk("both_counts", 256'({BubbleCount, LoadUseCount}), 256'({16'hFFFF, 16'd1}));

    chk("sb_drained", 256'(q.size()), 256'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
